ib_cnu6_c2v_return_buffer: RTL and testbench
============================================

// Module: ib_cnu6_c2v_return_buffer
// PURPOSE
//  Return path of the 6-input IB check-node unit. Takes the six c2v messages from
//  the last decomposed-LUT stage (F3) and delays them through a register pipeline
//  aligned to the v2c-side pipeline depth. Pushes them as one bundle into a FWFT FIFO.
//  Hands bundles to the VNU side over a valid/ready handshake, so VNU stalls never
//  freeze the CNU LUT cascade.
// PARAMETERS
//  QUAN_SIZE       4  bits per c2v message
//  PIPELINE_DEPTH  3  alignment depth; PIPELINE_DEPTH-1 input register stages (>=2)
//  FIFO_DEPTH      4  bundles held; power of two, >=2
//  CNT_W           $clog2(FIFO_DEPTH+1)  width of fifo_count (localparam)
// PORTS
//  read_clk        input   1              clock; all logic on rising edge
//  rstn            input   1              synchronous reset, active-low
//  c2v{0..5}_in    input   QUAN_SIZE each c2v messages from F3 LUT outputs
//  c2v_valid_in    input   1              bundle on c2v*_in is valid this cycle
//  flush           input   1              sync clear of pipeline valids + FIFO (iteration abort)
//  vnu_ready       input   1              VNU side accepts head bundle this cycle
//  c2v{0..5}_out   output  QUAN_SIZE each head bundle of FIFO
//  c2v_valid_out   output  1              head bundle valid (= fifo_count != 0)
//  fifo_count      output  CNT_W          bundles currently stored
//  overflow        output  1              sticky: a bundle was dropped because FIFO was full
// BEHAVIOUR
//  Reset (rstn=0 at edge): all pipeline data/valid regs 0, wr/rd ptr 0, fifo_count 0,
//   overflow 0; hence c2v*_out=0, c2v_valid_out=0. Reset overrides every other input.
//  Input pipeline: PIPELINE_DEPTH-1 stages; data and valid shift together every cycle
//   (no stall; the pipeline never back-pressures the CNU). Stage-out valid = push.
//  Latency: c2v_valid_in=1 in cycle t, FIFO empty, no flush -> c2v_valid_out=1 and
//   data visible in cycle t+PIPELINE_DEPTH.
//  Pop = c2v_valid_out & vnu_ready. Push = stage-out valid & ~flush.
//  FWFT: c2v*_out shows storage[rd_ptr] combinationally; forced to 0 when count==0.
//  Count/pointer rules per edge:
//   push & ~pop & ~full          : write at wr_ptr, wr_ptr+1, count+1
//   pop & ~push                  : rd_ptr+1, count-1
//   push & pop (count>0)         : write and read; count unchanged; legal when full
//   push & full & ~pop           : bundle dropped, state unchanged, overflow<=1
//  Pointers wrap modulo FIFO_DEPTH (log2 bits, natural wrap).
//  vnu_ready while empty: no effect. Push into empty FIFO: visible next cycle, never same-cycle bypass.
//  flush=1: next edge clears pointers, count and all pipeline valid bits.
//   In-flight and stored bundles are discarded; flush beats push/pop in the same cycle.
//   overflow is NOT cleared by flush (rstn only).
//  Data regs need no clear on flush; only valids and pointers are cleared.
// TESTING
//  1 Reset: hold rstn=0 3 cycles with c2v_valid_in=1 -> all outputs 0, count 0.
//  2 Latency: single bundle 1,2,3,4,5,6 at t, vnu_ready=1 -> valid_out only in cycle t+3;
//    outputs 1..6 then; count back to 0 at t+4.
//  3 Fill/overflow: vnu_ready=0, 5 back-to-back bundles (k,k..) k=1..5 -> count saturates 4,
//    overflow=1. Then vnu_ready=1 pops 1,2,3,4 in order; bundle 5 is never seen.
//  4 Full+simultaneous: count=4, push 9s while vnu_ready=1 -> count stays 4, overflow stays 0,
//    9s come out last.
//  5 Flush: 2 bundles stored + 1 in pipeline, flush=1 one cycle -> count 0, valid_out 0.
//    The in-flight bundle never appears; prior overflow value kept.
//  6 Wrap: 10 bundles, random vnu_ready 50% -> output order = input order; count never >4 or <0.

Source files
------------

// File: rtl/ib_cnu6_c2v_return_buffer_if.sv
// Purpose: bundles the CNU-side c2v inputs and the VNU-side head-of-FIFO outputs of the c2v return buffer.
// Latency: none; wires only.
// Backpressure: vnu_ready stalls only the FIFO head. The CNU side (c2v*_in, c2v_valid_in) is never back-pressured.
// Ports: master = CNU/VNU environment (drives inputs), slave = return buffer (drives outputs).
interface ib_cnu6_c2v_return_buffer_if #(
    parameter int QUAN_SIZE  = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [QUAN_SIZE-1:0] c2v0_in, c2v1_in, c2v2_in, c2v3_in, c2v4_in, c2v5_in;
    logic                 c2v_valid_in;
    logic                 flush;
    logic                 vnu_ready;
    logic [QUAN_SIZE-1:0] c2v0_out, c2v1_out, c2v2_out, c2v3_out, c2v4_out, c2v5_out;
    logic                 c2v_valid_out;
    logic [CNT_W-1:0]     fifo_count;
    logic                 overflow;

    modport master (
        output c2v0_in, c2v1_in, c2v2_in, c2v3_in, c2v4_in, c2v5_in,
        output c2v_valid_in, flush, vnu_ready,
        input  c2v0_out, c2v1_out, c2v2_out, c2v3_out, c2v4_out, c2v5_out,
        input  c2v_valid_out, fifo_count, overflow
    );

    modport slave (
        input  c2v0_in, c2v1_in, c2v2_in, c2v3_in, c2v4_in, c2v5_in,
        input  c2v_valid_in, flush, vnu_ready,
        output c2v0_out, c2v1_out, c2v2_out, c2v3_out, c2v4_out, c2v5_out,
        output c2v_valid_out, fifo_count, overflow
    );
endinterface

// File: rtl/ib_cnu6_c2v_return_buffer.sv
// Purpose: aligns the six F3 c2v messages to the v2c pipeline depth, then queues them as bundles for the VNU.
// Latency: PIPELINE_DEPTH cycles from c2v_valid_in to c2v_valid_out when the FIFO is empty (FWFT head).
// Backpressure: vnu_ready stalls only the FIFO. A push into a full FIFO without a pop is dropped, and sticky overflow is set.
// Ports: read_clk/rstn (synchronous active-low reset); bus (slave modport) carries c2v*_in, c2v_valid_in, flush,
//        vnu_ready in, and c2v*_out, c2v_valid_out, fifo_count, overflow out.
module ib_cnu6_c2v_return_buffer #(
    parameter int QUAN_SIZE      = 4,
    parameter int PIPELINE_DEPTH = 3,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          read_clk,
    input  logic                          rstn,
    ib_cnu6_c2v_return_buffer_if.slave    bus
);
    localparam int NSTG  = PIPELINE_DEPTH - 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BW    = 6 * QUAN_SIZE;

    typedef logic [BW-1:0] bundle_t;

    // Message 0 occupies the LSBs of a bundle.
    bundle_t in_dat;
    assign in_dat = {bus.c2v5_in, bus.c2v4_in, bus.c2v3_in, bus.c2v2_in, bus.c2v1_in, bus.c2v0_in};

    // Alignment pipeline: shifts every cycle and never stalls the LUT cascade.
    bundle_t           stg_dat [NSTG];
    logic [NSTG-1:0]   stg_vld;

    always_ff @(posedge read_clk) begin
        if (!rstn) begin
            for (int i = 0; i < NSTG; i++) stg_dat[i] <= '0;
            stg_vld <= '0;
        end else begin
            stg_dat[0] <= in_dat;
            for (int i = 1; i < NSTG; i++) stg_dat[i] <= stg_dat[i-1];
            // Flush also kills the bundle entering this cycle.
            stg_vld <= bus.flush ? '0 : {stg_vld[NSTG-2:0], bus.c2v_valid_in};
        end
    end

    // FWFT FIFO.
    bundle_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               ovf;
    logic               empty, full, push, pop, do_write;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign push     = stg_vld[NSTG-1] & ~bus.flush;
    assign pop      = ~empty & bus.vnu_ready;
    // A simultaneous pop frees the head slot, so a push into a full FIFO is still legal.
    assign do_write = push & (pop | ~full);

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge read_clk) begin
        if (rstn && do_write) mem[wr_ptr] <= stg_dat[NSTG-1];
    end

    always_ff @(posedge read_clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (bus.flush) begin
            // Overflow is deliberately kept across a flush.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop && !full) count <= count + 1'b1;
            else if (pop && !push)     count <= count - 1'b1;
            if (push && full && !pop)  ovf <= 1'b1;
        end
    end

    bundle_t head;
    assign head = empty ? '0 : mem[rd_ptr];

    assign bus.c2v0_out      = head[0*QUAN_SIZE +: QUAN_SIZE];
    assign bus.c2v1_out      = head[1*QUAN_SIZE +: QUAN_SIZE];
    assign bus.c2v2_out      = head[2*QUAN_SIZE +: QUAN_SIZE];
    assign bus.c2v3_out      = head[3*QUAN_SIZE +: QUAN_SIZE];
    assign bus.c2v4_out      = head[4*QUAN_SIZE +: QUAN_SIZE];
    assign bus.c2v5_out      = head[5*QUAN_SIZE +: QUAN_SIZE];
    assign bus.c2v_valid_out = ~empty;
    assign bus.fifo_count    = count;
    assign bus.overflow      = ovf;
endmodule

// File: tb/tb_ib_cnu6_c2v_return_buffer.sv
// Purpose: directed and random stimulus for the c2v return buffer, checked against a queue-based reference model.
// Latency: the model schedules each accepted bundle to reach the FIFO PIPELINE_DEPTH-1 edges after its capture edge.
// Backpressure: vnu_ready is driven by the bench; the model pops its queue whenever its head is valid and ready is high.
module tb_ib_cnu6_c2v_return_buffer;
    localparam int Q  = 4;
    localparam int PD = 3;
    localparam int FD = 4;
    localparam int CW = $clog2(FD + 1);

    logic read_clk = 1'b0;
    logic rstn     = 1'b0;
    always #5 read_clk = ~read_clk;

    ib_cnu6_c2v_return_buffer_if #(.QUAN_SIZE(Q), .FIFO_DEPTH(FD)) bus ();

    ib_cnu6_c2v_return_buffer #(.QUAN_SIZE(Q), .PIPELINE_DEPTH(PD), .FIFO_DEPTH(FD)) dut (
        .read_clk (read_clk),
        .rstn     (rstn),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, plus bundles travelling toward the FIFO with their arrival edge.
    typedef struct packed {
        logic [23:0] d;
        int          due;
    } flight_t;

    logic [23:0] mq [$];
    flight_t     infl [$];
    int          edge_n = 0;
    bit          m_ovf  = 1'b0;

    task automatic model_edge(bit rst_n, bit v, logic [23:0] d, bit fl, bit rdy);
        edge_n++;
        if (!rst_n) begin
            mq.delete(); infl.delete(); m_ovf = 1'b0;
        end else if (fl) begin
            mq.delete(); infl.delete();
        end else begin
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            while (infl.size() > 0 && infl[0].due == edge_n) begin
                if (mq.size() < FD) mq.push_back(infl[0].d);
                else m_ovf = 1'b1;
                void'(infl.pop_front());
            end
            if (v) infl.push_back('{d: d, due: edge_n + PD - 1});
        end
    endtask

    task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        logic [23:0] exp_d;
        logic [23:0] obs_d;
        exp_d = (mq.size() != 0) ? mq[0] : 24'h0;
        obs_d = {bus.c2v5_out, bus.c2v4_out, bus.c2v3_out, bus.c2v2_out, bus.c2v1_out, bus.c2v0_out};
        check_val({tag, ".valid"}, 32'(bus.c2v_valid_out), 32'(mq.size() != 0));
        check_val({tag, ".count"}, 32'(bus.fifo_count), 32'(mq.size()));
        check_val({tag, ".data"}, 32'(obs_d), 32'(exp_d));
        check_val({tag, ".ovf"}, 32'(bus.overflow), 32'(m_ovf));
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance the model, then check outputs 1 ns later.
    task automatic cycle(bit v, logic [23:0] d, bit fl, bit rdy, string tag);
        bit rst_n;
        bus.c2v_valid_in = v;
        {bus.c2v5_in, bus.c2v4_in, bus.c2v3_in, bus.c2v2_in, bus.c2v1_in, bus.c2v0_in} = d;
        bus.flush     = fl;
        bus.vnu_ready = rdy;
        rst_n = rstn;
        @(posedge read_clk);
        model_edge(rst_n, v, d, fl, rdy);
        #1;
        check_all(tag);
    endtask

    function automatic logic [23:0] rep(logic [3:0] k);
        return {k, k, k, k, k, k};
    endfunction

    initial begin
        bus.c2v_valid_in = 1'b0;
        bus.flush        = 1'b0;
        bus.vnu_ready    = 1'b0;
        {bus.c2v5_in, bus.c2v4_in, bus.c2v3_in, bus.c2v2_in, bus.c2v1_in, bus.c2v0_in} = '0;

        // Reset held 3 cycles with valid input present.
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 24'hABCDEF, 1'b0, 1'b1, "reset");
        check_val("reset_count", 32'(bus.fifo_count), 32'd0);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 24'h0, 1'b0, 1'b0, "idle");

        // Latency: single bundle 1..6 with ready high.
        cycle(1'b1, 24'h654321, 1'b0, 1'b1, "lat_in");
        cycle(1'b0, 24'h0, 1'b0, 1'b1, "lat_t1");
        check_val("lat_t1_valid", 32'(bus.c2v_valid_out), 32'd0);
        cycle(1'b0, 24'h0, 1'b0, 1'b1, "lat_t2");
        check_val("lat_t3_valid", 32'(bus.c2v_valid_out), 32'd1);
        check_val("lat_t3_data", 32'({bus.c2v5_out, bus.c2v4_out, bus.c2v3_out, bus.c2v2_out, bus.c2v1_out, bus.c2v0_out}), 32'h654321);
        cycle(1'b0, 24'h0, 1'b0, 1'b1, "lat_t3");
        check_val("lat_t4_count", 32'(bus.fifo_count), 32'd0);

        // Full FIFO with simultaneous push and pop.
        for (int k = 1; k <= 4; k++) cycle(1'b1, rep(4'(k)), 1'b0, 1'b0, "full_fill");
        cycle(1'b0, 24'h0, 1'b0, 1'b0, "full_wait");
        cycle(1'b0, 24'h0, 1'b0, 1'b0, "full_wait");
        check_val("full_count", 32'(bus.fifo_count), 32'd4);
        cycle(1'b1, rep(4'd9), 1'b0, 1'b0, "full_push9");
        cycle(1'b0, 24'h0, 1'b0, 1'b0, "full_stage");
        cycle(1'b0, 24'h0, 1'b0, 1'b1, "full_pushpop");
        check_val("full_pp_count", 32'(bus.fifo_count), 32'd4);
        check_val("full_pp_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 24'h0, 1'b0, 1'b1, "full_drain");
        check_val("full_drained", 32'(bus.fifo_count), 32'd0);

        // Fill past capacity: five bundles, the fifth is dropped.
        for (int k = 1; k <= 5; k++) cycle(1'b1, rep(4'(k)), 1'b0, 1'b0, "ovf_fill");
        cycle(1'b0, 24'h0, 1'b0, 1'b0, "ovf_wait");
        cycle(1'b0, 24'h0, 1'b0, 1'b0, "ovf_wait");
        check_val("ovf_count", 32'(bus.fifo_count), 32'd4);
        check_val("ovf_flag", 32'(bus.overflow), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            check_val("ovf_pop_order", 32'(bus.c2v0_out), 32'(k));
            cycle(1'b0, 24'h0, 1'b0, 1'b1, "ovf_pop");
        end
        check_val("ovf_no_5th", 32'(bus.c2v_valid_out), 32'd0);

        // Flush with two stored bundles and one in flight.
        cycle(1'b1, rep(4'd7), 1'b0, 1'b0, "fl_in");
        cycle(1'b1, rep(4'd8), 1'b0, 1'b0, "fl_in");
        cycle(1'b1, rep(4'd10), 1'b0, 1'b0, "fl_in");
        cycle(1'b0, 24'h0, 1'b0, 1'b0, "fl_wait");
        check_val("fl_pre_count", 32'(bus.fifo_count), 32'd2);
        cycle(1'b0, 24'h0, 1'b1, 1'b0, "fl_flush");
        check_val("fl_count", 32'(bus.fifo_count), 32'd0);
        check_val("fl_valid", 32'(bus.c2v_valid_out), 32'd0);
        check_val("fl_ovf_kept", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 24'h0, 1'b0, 1'b1, "fl_after");

        // Random traffic across pointer wrap: 10 bundles, 50% ready.
        begin
            int sent;
            sent = 0;
            for (int i = 0; i < 200 && sent < 10; i++) begin
                bit v;
                v = 1'($urandom_range(0, 1));
                cycle(v, 24'($urandom), 1'b0, 1'($urandom_range(0, 1)), "wrap");
                check_val("wrap_count_max", 32'(bus.fifo_count <= CW'(FD)), 32'd1);
                if (v) sent++;
            end
            for (int i = 0; i < 20; i++) cycle(1'b0, 24'h0, 1'b0, 1'($urandom_range(0, 1)), "wrap_drain");
            for (int i = 0; i < 8; i++) cycle(1'b0, 24'h0, 1'b0, 1'b1, "wrap_final");
            check_val("wrap_empty", 32'(bus.fifo_count), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
